// File: rtl/isp_1bit_bbox_pkg.sv
// Shared definitions for the 1-bit mask bounding-box extractor: FSM state
// encoding, coordinate widths and the overlay border colour.
package isp_1bit_bbox_pkg;

    // Column coordinates cover up to 2047 pixels, row coordinates up to 1023 lines.
    localparam int X_W = 11;
    localparam int Y_W = 10;

    // RGB565 pure red, painted on the box border by the optional overlay.
    localparam logic [15:0] OVL_RED = 16'hF800;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACCUM      = 2'd1,
        PUBLISH    = 2'd2,
        ACCUM_WAIT = 2'd3
    } bbox_state_t;

endpackage

// File: rtl/isp_1bit_bbox_pix_coord.sv
// Pixel coordinate tracker for binary mask stages. Produces the column/row of
// the pixel presented this cycle, a pixel-take strobe, and registered vsync
// edge pulses (one cycle after the edge is first sampled).
module isp_pix_coord
    import isp_1bit_bbox_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           vsync_i,
    input  logic           href_i,
    input  logic           wr_en_i,
    output logic           pix_take_o,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           vsync_rise_o,
    output logic           vsync_fall_o
);

    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

    logic           vsync_q;
    logic           href_q;
    logic           rise_q;
    logic           fall_q;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           href_fall;

    assign pix_take_o   = wr_en_i & href_i & ~vsync_i;
    assign href_fall    = href_q & ~href_i;
    assign x_o          = x_q;
    assign y_o          = y_q;
    assign vsync_rise_o = rise_q;
    assign vsync_fall_o = fall_q;

    // Next coordinates: held at the origin through blanking so every frame
    // starts at (0,0); columns and rows saturate instead of wrapping.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (vsync_i) begin
            x_d = '0;
            y_d = '0;
        end else if (href_fall) begin
            x_d = '0;
            if (y_q != Y_LAST) begin
                y_d = y_q + 1'b1;
            end
        end else if (pix_take_o && (x_q != X_LAST)) begin
            x_d = x_q + 1'b1;
        end
    end

    // Sync history, edge pulses and coordinate registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            vsync_q <= vsync_i;
            href_q  <= href_i;
            rise_q  <= vsync_i & ~vsync_q;
            fall_q  <= ~vsync_i & vsync_q;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

endmodule

// File: rtl/isp_1bit_bbox.sv
// Per-frame motion bounding box extractor for a cleaned 1-bit motion mask.
// Accumulates min/max column and row plus a saturating foreground count over
// each frame and publishes one registered box per frame end.
// Optional feature: define BBOX_OVERLAY_EN to add a one-cycle-delayed RGB565
// pass-through that paints the published box border red.
module isp_1bit_bbox
    import isp_1bit_bbox_pkg::*;
#(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int MIN_PIX = 64,
    parameter int CNT_W   = 20
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             pre_vsync,
    input  logic             pre_href,
    input  logic             pre_wr_en,
    input  logic             img_1bit_in,
    output logic             box_valid,
    output logic             box_update,
    output logic [X_W-1:0]   box_x_min,
    output logic [X_W-1:0]   box_x_max,
    output logic [Y_W-1:0]   box_y_min,
    output logic [Y_W-1:0]   box_y_max,
    output logic [CNT_W-1:0] box_pix_cnt
`ifdef BBOX_OVERLAY_EN
    ,
    input  logic [15:0]      ovl_data_in,
    output logic [15:0]      ovl_data_out
`endif
);

    localparam logic [X_W-1:0]   X_LAST  = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIX);

    bbox_state_t state_q, state_d;
    logic accum_en, acc_clear, publish;

    logic           pix_take;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic           vsync_rise, vsync_fall;

    logic [X_W-1:0]   x_min_q, x_min_d, x_max_q, x_max_d;
    logic [Y_W-1:0]   y_min_q, y_min_d, y_max_q, y_max_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;

    logic             box_valid_q, box_valid_d;
    logic             box_update_q, box_update_d;
    logic [X_W-1:0]   box_x_min_q, box_x_min_d, box_x_max_q, box_x_max_d;
    logic [Y_W-1:0]   box_y_min_q, box_y_min_d, box_y_max_q, box_y_max_d;
    logic [CNT_W-1:0] box_pix_cnt_q, box_pix_cnt_d;

    isp_pix_coord #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_coord (
        .clk_i        (sys_clk),
        .rst_i        (sys_rst),
        .vsync_i      (pre_vsync),
        .href_i       (pre_href),
        .wr_en_i      (pre_wr_en),
        .pix_take_o   (pix_take),
        .x_o          (pix_x),
        .y_o          (pix_y),
        .vsync_rise_o (vsync_rise),
        .vsync_fall_o (vsync_fall)
    );

    // FSM state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= WAIT_FRAME;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a rising vsync only ends a frame that was fully accumulated.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_FRAME: if (vsync_fall) state_d = ACCUM;
            ACCUM:      if (vsync_rise) state_d = PUBLISH;
            PUBLISH:    state_d = ACCUM_WAIT;
            ACCUM_WAIT: if (vsync_fall) state_d = ACCUM;
            default:    state_d = WAIT_FRAME;
        endcase
    end

    // FSM outputs: accumulate, clear or publish control.
    always_comb begin
        accum_en  = 1'b0;
        acc_clear = 1'b0;
        publish   = 1'b0;
        case (state_q)
            ACCUM:      accum_en  = 1'b1;
            PUBLISH:    publish   = 1'b1;
            default:    acc_clear = 1'b1;
        endcase
    end

    // Accumulator next state: bounds track foreground pixels, count saturates.
    always_comb begin
        x_min_d   = x_min_q;
        x_max_d   = x_max_q;
        y_min_d   = y_min_q;
        y_max_d   = y_max_q;
        pix_cnt_d = pix_cnt_q;
        if (acc_clear) begin
            x_min_d   = X_LAST;
            x_max_d   = '0;
            y_min_d   = Y_LAST;
            y_max_d   = '0;
            pix_cnt_d = '0;
        end else if (accum_en && pix_take && img_1bit_in) begin
            if (pix_x < x_min_q) x_min_d = pix_x;
            if (pix_x > x_max_q) x_max_d = pix_x;
            if (pix_y < y_min_q) y_min_d = pix_y;
            if (pix_y > y_max_q) y_max_d = pix_y;
            if (pix_cnt_q != CNT_MAX) pix_cnt_d = pix_cnt_q + 1'b1;
        end
    end

    // Accumulator registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            x_min_q   <= X_LAST;
            x_max_q   <= '0;
            y_min_q   <= Y_LAST;
            y_max_q   <= '0;
            pix_cnt_q <= '0;
        end else begin
            x_min_q   <= x_min_d;
            x_max_q   <= x_max_d;
            y_min_q   <= y_min_d;
            y_max_q   <= y_max_d;
            pix_cnt_q <= pix_cnt_d;
        end
    end

    // Published box: bounds only meaningful when enough foreground was seen,
    // the count is always reported.
    always_comb begin
        box_valid_d   = box_valid_q;
        box_update_d  = 1'b0;
        box_x_min_d   = box_x_min_q;
        box_x_max_d   = box_x_max_q;
        box_y_min_d   = box_y_min_q;
        box_y_max_d   = box_y_max_q;
        box_pix_cnt_d = box_pix_cnt_q;
        if (publish) begin
            box_update_d  = 1'b1;
            box_pix_cnt_d = pix_cnt_q;
            if (pix_cnt_q >= MIN_CNT) begin
                box_valid_d = 1'b1;
                box_x_min_d = x_min_q;
                box_x_max_d = x_max_q;
                box_y_min_d = y_min_q;
                box_y_max_d = y_max_q;
            end else begin
                box_valid_d = 1'b0;
                box_x_min_d = '0;
                box_x_max_d = '0;
                box_y_min_d = '0;
                box_y_max_d = '0;
            end
        end
    end

    // Published box registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            box_valid_q   <= 1'b0;
            box_update_q  <= 1'b0;
            box_x_min_q   <= '0;
            box_x_max_q   <= '0;
            box_y_min_q   <= '0;
            box_y_max_q   <= '0;
            box_pix_cnt_q <= '0;
        end else begin
            box_valid_q   <= box_valid_d;
            box_update_q  <= box_update_d;
            box_x_min_q   <= box_x_min_d;
            box_x_max_q   <= box_x_max_d;
            box_y_min_q   <= box_y_min_d;
            box_y_max_q   <= box_y_max_d;
            box_pix_cnt_q <= box_pix_cnt_d;
        end
    end

    assign box_valid   = box_valid_q;
    assign box_update  = box_update_q;
    assign box_x_min   = box_x_min_q;
    assign box_x_max   = box_x_max_q;
    assign box_y_min   = box_y_min_q;
    assign box_y_max   = box_y_max_q;
    assign box_pix_cnt = box_pix_cnt_q;

`ifdef BBOX_OVERLAY_EN
    logic        on_border;
    logic [15:0] ovl_q;

    // Border test for the pixel presented this cycle against the published box.
    always_comb begin
        on_border = 1'b0;
        if (box_valid_q && pix_take) begin
            if (((pix_x == box_x_min_q) || (pix_x == box_x_max_q)) &&
                (pix_y >= box_y_min_q) && (pix_y <= box_y_max_q)) begin
                on_border = 1'b1;
            end
            if (((pix_y == box_y_min_q) || (pix_y == box_y_max_q)) &&
                (pix_x >= box_x_min_q) && (pix_x <= box_x_max_q)) begin
                on_border = 1'b1;
            end
        end
    end

    // One-cycle video delay with the border painted red.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ovl_q <= '0;
        end else begin
            ovl_q <= on_border ? OVL_RED : ovl_data_in;
        end
    end

    assign ovl_data_out = ovl_q;
`endif

endmodule

// File: tb/tb_isp_1bit_bbox.sv
// Scoreboard bench for isp_1bit_bbox with an 8x4 image and MIN_PIX=2.
// Frame stimulus pushes the expected published box; a monitor pops and
// compares whenever box_update is seen. With BBOX_OVERLAY_EN defined, an
// overlay frame is also checked pixel by pixel.
`timescale 1ns/1ps
module tb_isp_1bit_bbox;

    localparam int IMG_W   = 8;
    localparam int IMG_H   = 4;
    localparam int MIN_PIX = 2;
    localparam int CNT_W   = 20;

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic             pre_vsync;
    logic             pre_href;
    logic             pre_wr_en;
    logic             img_1bit_in;
    logic             box_valid;
    logic             box_update;
    logic [10:0]      box_x_min, box_x_max;
    logic [9:0]       box_y_min, box_y_max;
    logic [CNT_W-1:0] box_pix_cnt;
`ifdef BBOX_OVERLAY_EN
    logic [15:0]      ovl_data_in;
    logic [15:0]      ovl_data_out;
`endif

    isp_1bit_bbox #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .MIN_PIX (MIN_PIX),
        .CNT_W   (CNT_W)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .pre_vsync   (pre_vsync),
        .pre_href    (pre_href),
        .pre_wr_en   (pre_wr_en),
        .img_1bit_in (img_1bit_in),
        .box_valid   (box_valid),
        .box_update  (box_update),
        .box_x_min   (box_x_min),
        .box_x_max   (box_x_max),
        .box_y_min   (box_y_min),
        .box_y_max   (box_y_max),
        .box_pix_cnt (box_pix_cnt)
`ifdef BBOX_OVERLAY_EN
        ,
        .ovl_data_in  (ovl_data_in),
        .ovl_data_out (ovl_data_out)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int valid;
        int xmin;
        int xmax;
        int ymin;
        int ymax;
        int cnt;
        int at_cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: compare every published box against the scoreboard.
    initial begin : box_monitor
        exp_t e;
        bit   prev_upd;
        prev_upd = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (prev_upd) chk("box_update_one_cycle", int'(box_update), 0);
            prev_upd = box_update;
            if (box_update === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_publish: got update at cyc %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    $display("publish: valid=%0d x=%0d..%0d y=%0d..%0d cnt=%0d cyc=%0d",
                             box_valid, box_x_min, box_x_max, box_y_min, box_y_max, box_pix_cnt, cyc);
                    chk("box_valid",     int'(box_valid),   e.valid);
                    chk("box_x_min",     int'(box_x_min),   e.xmin);
                    chk("box_x_max",     int'(box_x_max),   e.xmax);
                    chk("box_y_min",     int'(box_y_min),   e.ymin);
                    chk("box_y_max",     int'(box_y_max),   e.ymax);
                    chk("box_pix_cnt",   int'(box_pix_cnt), e.cnt);
                    chk("publish_cycle", cyc,               e.at_cyc);
                end
            end
        end
    end

`ifdef BBOX_OVERLAY_EN
    typedef struct {
        int          x;
        int          y;
        logic [15:0] v;
    } ovl_t;

    ovl_t ovl_sb[$];
    bit   ovl_active = 1'b0;
    bit   ovl_pend   = 1'b0;

    // Box (2,1)-(6,3) border, worked out by hand from the previous frame.
    function automatic logic [15:0] ovl_exp(input int x, input int y);
        bit border;
        border = ((x == 2 || x == 6) && y >= 1 && y <= 3) ||
                 ((y == 1 || y == 3) && x >= 2 && x <= 6);
        return border ? 16'hF800 : 16'h07E0;
    endfunction

    always @(posedge sys_clk) ovl_pend <= (ovl_sb.size() > 0);

    // Overlay monitor: one pixel expected per pending entry, one cycle late.
    initial begin : ovl_monitor
        ovl_t o;
        forever begin
            @(negedge sys_clk);
            if (ovl_pend && ovl_sb.size() > 0) begin
                o = ovl_sb.pop_front();
                $display("overlay: (%0d,%0d) out=%04h", o.x, o.y, ovl_data_out);
                chk($sformatf("ovl_x%0d_y%0d", o.x, o.y), int'(ovl_data_out), int'(o.v));
            end
        end
    end
`endif

    // One full frame: vsync low, IMG_H lines of npix strobes each, then vsync high.
    task automatic run_frame(input logic [3:0][15:0] fg, input logic [3:0][4:0] npix,
                             input bit href_on, input int e_valid, input int e_xmin,
                             input int e_xmax, input int e_ymin, input int e_ymax, input int e_cnt);
        exp_t e;
        @(negedge sys_clk);
        pre_vsync = 1'b0;
        repeat (2) @(negedge sys_clk);
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < int'(npix[r]); c++) begin
                pre_href    = href_on;
                pre_wr_en   = 1'b1;
                img_1bit_in = fg[r][c];
`ifdef BBOX_OVERLAY_EN
                ovl_data_in = 16'h07E0;
                if (ovl_active && href_on) begin
                    ovl_t o;
                    o.x = (c < IMG_W) ? c : IMG_W - 1;
                    o.y = r;
                    o.v = ovl_exp(o.x, o.y);
                    ovl_sb.push_back(o);
                end
`endif
                @(negedge sys_clk);
            end
            pre_href    = 1'b0;
            pre_wr_en   = 1'b0;
            img_1bit_in = 1'b0;
            repeat (2) @(negedge sys_clk);
        end
        pre_vsync = 1'b1;
        e.valid  = e_valid;
        e.xmin   = e_xmin;
        e.xmax   = e_xmax;
        e.ymin   = e_ymin;
        e.ymax   = e_ymax;
        e.cnt    = e_cnt;
        e.at_cyc = cyc + 3;
        exp_q.push_back(e);
        repeat (6) @(negedge sys_clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"},  int'(box_valid),   0);
        chk({tag, "_update"}, int'(box_update),  0);
        chk({tag, "_x_min"},  int'(box_x_min),   0);
        chk({tag, "_x_max"},  int'(box_x_max),   0);
        chk({tag, "_y_min"},  int'(box_y_min),   0);
        chk({tag, "_y_max"},  int'(box_y_max),   0);
        chk({tag, "_cnt"},    int'(box_pix_cnt), 0);
`ifdef BBOX_OVERLAY_EN
        chk({tag, "_ovl"},    int'(ovl_data_out), 0);
`endif
    endtask

    // Watchdog: the run is short, so a stall means the bench lost sync.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        sys_rst     = 1'b1;
        pre_vsync   = 1'b1;
        pre_href    = 1'b0;
        pre_wr_en   = 1'b0;
        img_1bit_in = 1'b0;
`ifdef BBOX_OVERLAY_EN
        ovl_data_in = 16'h0000;
`endif
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        chk_outputs_zero("reset");
        repeat (3) @(negedge sys_clk);

        // Single foreground pixel at (3,1): below MIN_PIX, bounds forced to 0.
        run_frame({16'h0000, 16'h0000, 16'h0008, 16'h0000}, {5'd8, 5'd8, 5'd8, 5'd8},
                  1'b1, 0, 0, 0, 0, 0, 1);

        // Foreground at (2,1) and (6,3): valid box 2..6 x 1..3.
        run_frame({16'h0040, 16'h0000, 16'h0004, 16'h0000}, {5'd8, 5'd8, 5'd8, 5'd8},
                  1'b1, 1, 2, 6, 1, 3, 2);

        // Strobes without href are not pixels.
        run_frame({16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF}, {5'd8, 5'd8, 5'd8, 5'd8},
                  1'b0, 0, 0, 0, 0, 0, 0);

        // 10 strobes on line 0, set at index 5 and 9: index 9 lands on column 7.
        run_frame({16'h0000, 16'h0000, 16'h0000, 16'h0220}, {5'd8, 5'd8, 5'd8, 5'd10},
                  1'b1, 1, 5, 7, 0, 0, 2);

        // Reset in the middle of a frame; the rest of that frame is ignored.
        @(negedge sys_clk);
        pre_vsync = 1'b0;
        repeat (2) @(negedge sys_clk);
        pre_href    = 1'b1;
        pre_wr_en   = 1'b1;
        img_1bit_in = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        chk_outputs_zero("midreset");
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (4) @(negedge sys_clk);
        pre_href    = 1'b0;
        pre_wr_en   = 1'b0;
        repeat (2) @(negedge sys_clk);
        pre_href    = 1'b1;
        pre_wr_en   = 1'b1;
        repeat (8) @(negedge sys_clk);
        pre_href    = 1'b0;
        pre_wr_en   = 1'b0;
        img_1bit_in = 1'b0;
        repeat (2) @(negedge sys_clk);
        pre_vsync = 1'b1;
        repeat (6) @(negedge sys_clk);
        chk_outputs_zero("after_partial");

        // First full frame after reset publishes normally.
        run_frame({16'h0040, 16'h0000, 16'h0004, 16'h0000}, {5'd8, 5'd8, 5'd8, 5'd8},
                  1'b1, 1, 2, 6, 1, 3, 2);

`ifdef BBOX_OVERLAY_EN
        // Green video over the published (2,1)-(6,3) box; empty mask this frame.
        ovl_active = 1'b1;
        run_frame({16'h0000, 16'h0000, 16'h0000, 16'h0000}, {5'd8, 5'd8, 5'd8, 5'd8},
                  1'b1, 0, 0, 0, 0, 0, 0);
        ovl_active = 1'b0;
        chk("ovl_scoreboard_drained", ovl_sb.size(), 0);
`endif

        repeat (10) @(negedge sys_clk);
        chk("box_scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
